// File: rtl/pe_dma_pkg.sv
// Shared types and constants for the PE single-channel DMA copy engine.
package pe_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } dma_state_e;

  localparam int MODE_SRC_STRIDE = 1;
  localparam int MODE_DST_STRIDE = 2;

  localparam logic [31:0] WORD_INC = 32'd4;

endpackage

// File: rtl/pe_dma_engine.sv
// Word-granular copy engine: read one word into a staging buffer, write it
// out, repeat; optional strided source/destination, sticky done/error.
module pe_dma_engine
  import pe_dma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dma_src_addr,
  input  logic [31:0] dma_dst_addr,
  input  logic [31:0] dma_size,
  input  logic [31:0] dma_stride,
  input  logic [2:0]  dma_mode,
  input  logic        dma_start,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_error,
  output logic        dma_done_pulse,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  input  logic        rd_err,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  input  logic        wr_err
);

  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TMO_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  dma_state_e state_q, state_d;

  logic             start_q, start_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      stride_q, stride_d;
  logic             sstr_q, sstr_d;
  logic             dstr_q, dstr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             pulse_q, pulse_d;
  logic             rd_req_q, rd_req_d;
  logic             wr_req_q, wr_req_d;

  logic        launch;
  logic        tmo_hit;
  logic        misalign;
  logic [31:0] src_inc;
  logic [31:0] dst_inc;
  logic        unused_mode;

  // mode bit 0 mirrors dma_start and carries no meaning here
  assign unused_mode = dma_mode[0];

  assign launch   = dma_start & ~start_q & (state_q == S_IDLE);
  assign tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);
  assign misalign = (dma_src_addr[1:0] != 2'b00) |
                    (dma_dst_addr[1:0] != 2'b00);
  assign src_inc  = sstr_q ? stride_q : WORD_INC;
  assign dst_inc  = dstr_q ? stride_q : WORD_INC;

  always_comb begin
    state_d  = state_q;
    start_d  = dma_start;
    src_d    = src_q;
    dst_d    = dst_q;
    stride_d = stride_q;
    sstr_d   = sstr_q;
    dstr_d   = dstr_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q + CNT_ONE;
    buf_d    = buf_q;
    err_d    = err_q;
    done_d   = done_q;
    error_d  = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          src_d    = dma_src_addr;
          dst_d    = dma_dst_addr;
          stride_d = dma_stride;
          sstr_d   = dma_mode[MODE_SRC_STRIDE];
          dstr_d   = dma_mode[MODE_DST_STRIDE];
          rem_d    = CNT_W'(dma_size);
          err_d    = 1'b0;
          done_d   = 1'b0;
          error_d  = 1'b0;
          if (dma_size == '0) begin
            state_d = S_FIN;
          end else if (misalign) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (rd_ack) begin
          if (rd_err) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            buf_d   = rd_data;
            state_d = S_WR;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WR: begin
        if (wr_ack) begin
          if (wr_err) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            rem_d   = rem_q - CNT_ONE;
            src_d   = src_q + src_inc;
            dst_d   = dst_q + dst_inc;
            state_d = (rem_q == CNT_ONE) ? S_FIN : S_RD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
    endcase

    // every new request gets a fresh wait budget
    if (state_d != state_q) tmo_d = '0;

    if (state_d == S_FIN && state_q != S_FIN) begin
      done_d  = ~err_d;
      error_d = err_d;
    end

    busy_d   = (state_d != S_IDLE);
    pulse_d  = (state_d == S_FIN);
    rd_req_d = (state_d == S_RD);
    wr_req_d = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      stride_q <= '0;
      sstr_q   <= 1'b0;
      dstr_q   <= 1'b0;
      rem_q    <= '0;
      tmo_q    <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      pulse_q  <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      stride_q <= stride_d;
      sstr_q   <= sstr_d;
      dstr_q   <= dstr_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      pulse_q  <= pulse_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign dma_busy       = busy_q;
  assign dma_done       = done_q;
  assign dma_error      = error_q;
  assign dma_done_pulse = pulse_q;
  assign rd_req         = rd_req_q;
  assign rd_addr        = src_q;
  assign wr_req         = wr_req_q;
  assign wr_addr        = dst_q;
  assign wr_data        = buf_q;

endmodule

// File: tb/tb_pe_dma_engine.sv
// Scoreboard bench for pe_dma_engine: a memory responder, a transfer-level
// reference model feeding expectation queues, and an independent monitor.
module tb_pe_dma_engine;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] dma_src_addr;
  logic [31:0] dma_dst_addr;
  logic [31:0] dma_size;
  logic [31:0] dma_stride;
  logic [2:0]  dma_mode;
  logic        dma_start;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_error;
  logic        dma_done_pulse;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_err;

  pe_dma_engine #(.TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
    .dma_size(dma_size), .dma_stride(dma_stride),
    .dma_mode(dma_mode), .dma_start(dma_start),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_error(dma_error), .dma_done_pulse(dma_done_pulse),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rq[$];
  logic [63:0] wq[$];
  bit          cq[$];

  int          rd_lat, wr_lat, rd_err_at, wr_err_at;
  int          rd_n, wr_n, rd_wait, wr_wait;
  logic [31:0] salt;
  int          last_wr_run;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // memory side: ack after a programmable wait, optional error on word k
  initial begin
    rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0; rd_data = 0;
    rd_wait = 0; wr_wait = 0;
    forever begin
      @(negedge clk);
      rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0;
      rd_data = $urandom;
      if (rst_n && rd_req) begin
        if (rd_wait >= rd_lat) begin
          rd_ack  = 1;
          rd_data = mem_val(rd_addr);
          rd_err  = (rd_n == rd_err_at);
          rd_n++;
          rd_wait = 0;
        end else rd_wait++;
      end else rd_wait = 0;
      if (rst_n && wr_req) begin
        if (wr_wait >= wr_lat) begin
          wr_ack = 1;
          wr_err = (wr_n == wr_err_at);
          wr_n++;
          wr_wait = 0;
        end else wr_wait++;
      end else wr_wait = 0;
    end
  end

  // monitor: compares every handshake and completion against the queues
  initial begin
    bit          pend, ok;
    bit          p_rd, p_rdack, p_wr, p_wrack;
    logic [31:0] p_rd_addr;
    logic [63:0] p_wr_aw;
    int          wr_run;
    pend = 0; p_rd = 0; p_rdack = 0; p_wr = 0; p_wrack = 0;
    p_rd_addr = 0; p_wr_aw = 0; wr_run = 0; last_wr_run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend = 0; p_rd = 0; p_wr = 0; wr_run = 0;
        continue;
      end
      if (pend) begin
        pend = 0;
        if (cq.size() == 0) flag("done_unexp");
        else begin
          ok = cq.pop_front();
          chk("done_flag", dma_done, ok);
          chk("error_flag", dma_error, !ok);
        end
        chk("pulse_len", dma_done_pulse, 0);
      end else if (dma_done_pulse) pend = 1;
      if (rd_req || wr_req) chk("one_req", rd_req & wr_req, 0);
      if (p_rd && !p_rdack && rd_req)
        chk("rd_hold", rd_addr, p_rd_addr);
      if (p_wr && !p_wrack && wr_req)
        chk("wr_hold", {wr_addr, wr_data}, p_wr_aw);
      if (rd_req && rd_ack) begin
        if (rq.size() == 0) flag("rd_unexp");
        else chk("rd_addr", rd_addr, rq.pop_front());
      end
      if (wr_req && wr_ack) begin
        if (wq.size() == 0) flag("wr_unexp");
        else chk("wr_addr_data", {wr_addr, wr_data}, wq.pop_front());
      end
      if (wr_req) wr_run++;
      else if (wr_run > 0) begin
        last_wr_run = wr_run;
        wr_run = 0;
      end
      p_rd = rd_req; p_rdack = rd_ack; p_rd_addr = rd_addr;
      p_wr = wr_req; p_wrack = wr_ack; p_wr_aw = {wr_addr, wr_data};
    end
  end

  // transfer-level reference: closed-form addresses, data from memory model
  task automatic model(input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] n, input logic [31:0] st,
                       input logic [2:0] m);
    logic [31:0] si, di, ra, wa;
    bit          bad;
    bad = 0;
    if (n == 0) begin
      cq.push_back(1);
      return;
    end
    if (s[1:0] != 0 || d[1:0] != 0) begin
      cq.push_back(0);
      return;
    end
    si = m[1] ? st : 32'd4;
    di = m[2] ? st : 32'd4;
    for (int k = 0; k < int'(n); k++) begin
      ra = s + si * 32'(k);
      wa = d + di * 32'(k);
      if (rd_lat >= TMO) begin bad = 1; break; end
      rq.push_back(ra);
      if (k == rd_err_at) begin bad = 1; break; end
      if (wr_lat >= TMO) begin bad = 1; break; end
      wq.push_back({wa, mem_val(ra)});
      if (k == wr_err_at) begin bad = 1; break; end
    end
    cq.push_back(!bad);
  endtask

  task automatic cfg(input int rl, input int wl, input int re, input int we);
    rd_lat = rl; wr_lat = wl; rd_err_at = re; wr_err_at = we;
    salt = $urandom;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] n, input logic [31:0] st,
                        input logic [2:0] m);
    @(negedge clk);
    dma_start = 0;
    @(negedge clk);
    dma_src_addr = s; dma_dst_addr = d; dma_size = n;
    dma_stride = st; dma_mode = m; dma_start = 1;
    rd_n = 0; wr_n = 0;
    model(s, d, n, st, m);
  endtask

  task automatic wait_done();
    bit fin;
    fin = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cq.size() == 0 && !dma_busy) begin
        fin = 1;
        break;
      end
    end
    if (!fin) begin
      flag("wait_done_timeout");
      rq.delete(); wq.delete(); cq.delete();
    end
  endtask

  initial begin
    logic [31:0] s, d, n, st;
    logic [2:0]  m;
    bit          seen;
    rst_n = 0; dma_start = 0; dma_src_addr = 0; dma_dst_addr = 0;
    dma_size = 0; dma_stride = 0; dma_mode = 0;
    rd_n = 0; wr_n = 0;
    cfg(0, 0, -1, -1);
    repeat (3) @(negedge clk);
    chk("reset_ctl", {dma_busy, dma_done, dma_error, dma_done_pulse,
                      rd_req, wr_req}, 0);
    chk("reset_addr", {rd_addr, wr_addr}, 0);
    rst_n = 1;

    // linear copy
    cfg(0, 0, -1, -1);
    launch(32'h1000, 32'h2000, 4, 0, 3'b001);
    @(negedge clk);
    chk("busy_run", dma_busy, 1);
    wait_done();
    chk("busy_end", dma_busy, 0);

    // strided destination
    cfg(1, 0, -1, -1);
    launch(32'h1000, 32'h3000, 3, 32'h40, 3'b101);
    wait_done();

    // read error on word 2, then new start clears error
    cfg(0, 1, 1, -1);
    launch(32'h4000, 32'h5000, 5, 0, 3'b000);
    wait_done();
    cfg(0, 0, -1, -1);
    launch(32'h4100, 32'h5100, 1, 0, 3'b000);
    @(negedge clk);
    chk("err_cleared", {dma_error, dma_done}, 0);
    wait_done();

    // zero size and misaligned source
    launch(32'h1000, 32'h2000, 0, 0, 3'b000);
    wait_done();
    launch(32'h1002, 32'h2000, 3, 0, 3'b000);
    wait_done();

    // write stall: timeout, then ack on the final allowed cycle
    cfg(0, TMO, -1, -1);
    launch(32'h1000, 32'h2000, 1, 0, 3'b000);
    wait_done();
    chk("tmo_run", last_wr_run, TMO);
    cfg(0, TMO - 1, -1, -1);
    launch(32'h1000, 32'h2000, 1, 0, 3'b000);
    wait_done();
    chk("late_ack_run", last_wr_run, TMO);

    // start edge during busy ignored, new register values not picked up
    cfg(2, 2, -1, -1);
    launch(32'h6000, 32'h7000, 3, 0, 3'b000);
    repeat (3) @(negedge clk);
    dma_start = 0;
    @(negedge clk);
    dma_src_addr = 32'h9000; dma_size = 9; dma_start = 1;
    wait_done();

    // address wrap
    cfg(0, 0, -1, -1);
    launch(32'hFFFF_FFFC, 32'h8000, 2, 0, 3'b000);
    wait_done();

    // reset in the middle of a write
    cfg(0, 8, -1, -1);
    launch(32'hA000, 32'hB000, 3, 0, 3'b000);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_req) begin
        seen = 1;
        break;
      end
    end
    chk("wr_seen", seen, 1);
    #3 rst_n = 0;
    #1;
    chk("midrst_ctl", {dma_busy, dma_done, dma_error, dma_done_pulse,
                       rd_req, wr_req}, 0);
    chk("midrst_addr", {rd_addr, wr_addr}, 0);
    chk("midrst_data", wr_data, 0);
    rq.delete(); wq.delete(); cq.delete();
    dma_start = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // randomized transfers
    for (int t = 0; t < 40; t++) begin
      n  = $urandom_range(0, 6);
      s  = $urandom & 32'hFFFF_FFFC;
      d  = $urandom & 32'hFFFF_FFFC;
      st = $urandom_range(0, 64) * 4;
      m  = 3'($urandom);
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      cfg($urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1,
          ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1);
      launch(s, d, n, st, m);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("rq_left", rq.size(), 0);
    chk("wq_left", wq.size(), 0);
    chk("cq_left", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
